mux_tree_lut_pipe: RTL
======================

// Module: mux_tree_lut_pipe
// PURPOSE
//  Parametrised, pipelined successor to the fixed 4-input 2x1-MUX-tree function block.
//  Evaluates any N_VARS-input Boolean function held in a runtime-writable truth table.
//  The table is reduced by a binary 2x1-MUX tree, one register stage per tree level.
//  Sits between a config master (table writes) and a valid/ready operand stream.
// PARAMETERS
//  N_VARS      4        number of Boolean inputs (2..8); table depth = 2**N_VARS
//  TABLE_INIT  16'h3C5A reset truth table, width 2**N_VARS; default = m(1,3,4,6,10,11,12,13)
// PORTS
//  clk          in   1           rising-edge clock
//  rst_n        in   1           asynchronous active-low reset
//  cfg_tbl_wr   in   1           load whole table from cfg_tbl
//  cfg_tbl      in   2**N_VARS   new truth table; bit i = f(minterm i)
//  cfg_bit_wr   in   1           write one minterm bit
//  cfg_bit_idx  in   N_VARS      minterm index for cfg_bit_wr
//  cfg_bit_val  in   1           value for cfg_bit_wr
//  in_valid     in   1           operand valid
//  in_ready     out  1           operand accepted when in_valid && in_ready
//  in_vars      in   N_VARS      operand; in_vars[N_VARS-1]=A (MSB) .. in_vars[0]=LSB var
//  out_valid    out  1           result valid
//  out_ready    in   1           result consumed when out_valid && out_ready
//  out_y        out  1           f(in_vars) = table[in_vars]
// BEHAVIOUR
//  - Reset (async assert, sync release): table <= TABLE_INIT; all stage valids 0;
//    out_valid=0, out_y=0, in_ready=1.
//  - Tree: stage k (k=0..N_VARS-1) selects pairs of the previous level by in_vars[k]
//    (LSB first): even bit when 0, odd bit when 1. It registers 2**(N_VARS-1-k) bits,
//    the unused var bits (k+1..N_VARS-1) and a valid bit. The last stage drives out_y.
//  - Latency: exactly N_VARS cycles from acceptance to out_valid when not stalled.
//    Throughput: 1 result/cycle.
//  - Stall: stall = out_valid && !out_ready. When stalled, every stage holds,
//    in_ready=0 (combinational) and out_y/out_valid stay stable.
//    Bubbles do not collapse; the pipeline is globally enabled.
//  - Table snapshot: an operand uses the table value present in the cycle it is accepted.
//    Later writes never affect in-flight operands.
//  - Config writes are accepted in any cycle, including during a stall;
//    they take effect on the next edge.
//  - Simultaneous cfg_tbl_wr and cfg_bit_wr: apply the full load, then overlay the bit
//    write (bit write wins on its index).
//  - Write in the same cycle as accept: the accepted operand sees the old table.
//  - Reset mid-operation: in-flight results are discarded (no out_valid);
//    table returns to TABLE_INIT.
//  - in_vars is ignored when !in_valid. An X on in_vars with in_valid=0 must not
//    propagate to out_y.
// TESTING
//  1 Reset, then stream in_vars 0..15 back-to-back with out_ready=1 -> out_valid first at
//    cycle 4 after the first accept; out_y sequence 0,1,0,1,1,0,1,0,0,0,1,1,1,1,0,0.
//  2 Hold out_ready=0 for 3 cycles with 4 operands in flight -> in_ready=0,
//    out_y held stable; after release the sequence continues with no loss or duplication.
//  3 cfg_tbl_wr=1, cfg_tbl=16'hFFFF in the same cycle as accepting in_vars=0 ->
//    that result=0 (old table); the next accepted operand in_vars=0 -> 1.
//  4 cfg_bit_wr idx=5 val=1 -> eval 5 gives 1.
//    Same cycle: cfg_tbl_wr 16'h0000 + cfg_bit_wr idx=2 val=1 -> table=16'h0004.
//  5 Assert rst_n=0 for 1 cycle with 3 operands in flight ->
//    no out_valid afterwards until new input; eval 13 gives 1 (TABLE_INIT restored).
//  6 N_VARS=6, random 64-bit table, 200 random operands with random out_ready ->
//    every result matches the reference model table[in_vars], in order.

Source files
------------

// File: rtl/mux_tree_lut_pipe.sv
// Runtime-writable N_VARS-input truth table evaluated by a pipelined 2:1 mux tree,
// one register stage per tree level, with valid/ready handshaking on both sides.
module mux_tree_lut_pipe #(
    parameter int                  N_VARS     = 4,
    parameter logic [2**N_VARS-1:0] TABLE_INIT = 16'h3C5A
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_tbl_wr,
    input  logic [2**N_VARS-1:0]    cfg_tbl,
    input  logic                    cfg_bit_wr,
    input  logic [N_VARS-1:0]       cfg_bit_idx,
    input  logic                    cfg_bit_val,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_VARS-1:0]       in_vars,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_y
);

    localparam int DEPTH  = 2**N_VARS;
    localparam int VARS_W = (N_VARS * (N_VARS - 1)) / 2;

    logic [DEPTH-1:0]  table_reg;
    logic [DEPTH-1:0]  table_next;

    // All stage data packed back to back: stage k occupies 2**(N_VARS-1-k) bits
    // starting at DEPTH - 2**(N_VARS-k); the final stage is the single bit at DEPTH-2.
    logic [DEPTH-2:0]  data_reg;
    logic [DEPTH-2:0]  data_next;
    // Stage k carries the N_VARS-1-k select bits still needed by later levels.
    logic [VARS_W-1:0] vars_reg;
    logic [VARS_W-1:0] vars_next;
    logic [N_VARS-1:0] valid_reg;
    logic [N_VARS-1:0] valid_next;

    logic stall;
    logic advance;
    logic accept;

    assign out_valid = valid_reg[N_VARS-1];
    assign out_y     = data_reg[DEPTH-2];
    assign stall     = out_valid && !out_ready;
    assign advance   = !stall;
    assign in_ready  = !stall;
    assign accept    = in_valid && in_ready;

    // Bit write is applied after the full load so it wins on its own index.
    always_comb begin
        table_next = table_reg;
        if (cfg_tbl_wr) begin
            table_next = cfg_tbl;
        end
        if (cfg_bit_wr) begin
            table_next[cfg_bit_idx] = cfg_bit_val;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_VARS; gi++) begin : g_stage
            localparam int PW   = 2**(N_VARS - gi);
            localparam int OW   = PW / 2;
            localparam int DOFF = DEPTH - PW;
            localparam int VOFF = gi * (N_VARS - 1) - (gi * (gi - 1)) / 2;

            logic [PW-1:0]        din;
            logic [N_VARS-gi-1:0] vin;
            logic                 vld_in;

            if (gi == 0) begin : g_src
                assign din    = table_reg;
                assign vin    = in_vars;
                assign vld_in = accept;
            end else begin : g_src
                assign din    = data_reg[DEPTH - 2*PW +: PW];
                assign vin    = vars_reg[VOFF - (N_VARS - gi) +: (N_VARS - gi)];
                assign vld_in = valid_reg[gi-1];
            end

            // Bubbles load zeros so undefined operands never reach out_y.
            genvar gj;
            for (gj = 0; gj < OW; gj++) begin : g_mux
                assign data_next[DOFF + gj] = vld_in ? (vin[0] ? din[2*gj+1] : din[2*gj]) : 1'b0;
            end

            if (gi < N_VARS - 1) begin : g_fwd
                assign vars_next[VOFF +: (N_VARS - 1 - gi)] =
                    vld_in ? vin[N_VARS-gi-1:1] : '0;
            end

            assign valid_next[gi] = vld_in;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            table_reg <= TABLE_INIT;
            data_reg  <= '0;
            vars_reg  <= '0;
            valid_reg <= '0;
        end else begin
            table_reg <= table_next;
            if (advance) begin
                data_reg  <= data_next;
                vars_reg  <= vars_next;
                valid_reg <= valid_next;
            end
        end
    end

endmodule
